brew_controller: RTL and testbench
==================================

# brew_controller

Drink-sequencing controller for the coffee machine. Consumes the slow 1 Hz square wave from the frequency divider as its seconds time base, accepts coins, drink selection, start and cancel, and drives the grinder, heater and pump through a timed brew sequence. Issues change on purchase or cancel, and exposes state and seconds-remaining for the display logic.

## Interface
- `PRICE`, default 5: drink price in coin units; must be 1..2^CREDIT_W-1.
- `CREDIT_W`, default 4: width of `credit` and `change`.
- `GRIND_SEC`, default 3: grind phase length in seconds; must be ≥1.
- `HEAT_SEC`, default 4: heat phase length in seconds; must be ≥1.
- `POUR_SEC`, default 5: base pour length in seconds; must be ≥1 and ≤11.
- `DONE_SEC`, default 2: done-indication length in seconds; must be ≥1.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `sec_clk` in 1: divider output, asynchronous to sampling. Each rising edge is one second.
- `coin` in 1: one-cycle pulse; adds one unit of credit.
- `sel` in 2: drink code. 0 espresso, 1 americano, 2 latte, 3 invalid. Sampled on `start`.
- `start` in 1: one-cycle purchase request.
- `cancel` in 1: one-cycle cancel request.
- `state` out 3: IDLE=0, GRIND=1, HEAT=2, POUR=3, DONE=4.
- `credit` out CREDIT_W: current credit.
- `change` out CREDIT_W: refund amount. Valid only while `change_valid` is high.
- `change_valid` out 1: one-cycle pulse.
- `grinder_on`, `heater_on`, `pump_on` out 1: high in GRIND, HEAT and POUR respectively.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: high in DONE.
- `sec_left` out 4: seconds remaining in the current timed phase; 0 in IDLE.

## Operation
- **Time base:**
  - `sec_clk` passes through a 2-flop synchronizer, then a rising-edge detector, to produce an internal `tick`.
  - `tick` is high for exactly one `clk` cycle per `sec_clk` rising edge.
- **IDLE:**
  - `coin` increments `credit`. At the all-ones value, `credit` saturates and the coin is discarded.
  - `start` with `credit` ≥ PRICE and `sel` ≠ 3:
    - `change` = `credit` − PRICE and `change_valid` pulses.
    - `credit` is cleared and the selection is latched.
    - `sec_left` = GRIND_SEC and the state goes to GRIND.
  - Otherwise `start` is ignored; there is no pulse and no state change.
  - `cancel` with `credit` > 0: `change` = `credit`, `change_valid` pulses, and `credit` is cleared. With `credit` = 0, `cancel` is ignored.
  - `start` and `cancel` in the same cycle: `cancel` wins.
- **Busy states:**
  - `coin` still accumulates into `credit`, for the next purchase. `start` is ignored.
- **Phase sequencing:**
  - In each timed state (GRIND, HEAT, POUR, DONE), every `tick` decrements `sec_left`.
  - A `tick` while `sec_left` = 1 exits the phase and loads the next phase's length:
    - GRIND → HEAT, loading HEAT_SEC.
    - HEAT → POUR, loading POUR_SEC + 2·sel (5 / 7 / 9 with default parameters).
    - POUR → DONE, loading DONE_SEC.
    - DONE → IDLE, with `sec_left` = 0.
- **Cancel while busy:**
  - In GRIND: abort to IDLE, `change` = PRICE, `change_valid` pulses, and `sec_left` = 0.
  - In HEAT, POUR or DONE: ignored.
- **Credit arithmetic:** unsigned and saturating. `change` never underflows, because purchase requires `credit` ≥ PRICE.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Synchronizer and edge flops clear, credit and latched selection clear.
- **Reset mid-operation:** actuators drop immediately (asynchronously) and credit is lost. After release, `tick` cannot fire until `sec_clk` rises again; a `sec_clk` already high at release produces no tick.
- **Tick latency:** `tick` is high 2–3 `clk` edges after the `sec_clk` rise, depending on sampling phase.
- **Output registering:** all outputs are registered and change on the `clk` edge that performs the transition. `change_valid` and `change` are high/valid for exactly that one cycle.
- **Tick in the entry cycle:** a `tick` in the same cycle as a state entry is consumed by the exit logic of the old state only. The new phase's loaded value is not decremented that cycle. Each phase therefore ends on the N-th tick after entry.
- **Simultaneous coin and purchase/cancel:**
  - `coin` and `start` in the same IDLE cycle: the purchase test and `change` use the pre-cycle `credit`. The coin then sets the new `credit` to 1.
  - `coin` and `cancel` in the same IDLE cycle: the refund uses the pre-cycle `credit`. The coin sets the new `credit` to 1.
- **Mid-flight `sel` changes:** changes to `sel` after `start` are ignored.

## Test plan
All scenarios use default parameters and `sec_clk` with a 20-`clk` period.
- **Reset:** assert `rst`=0 mid-POUR → `pump_on`, `busy`, `state`, `credit` go to 0 immediately. After release, no tick until the next `sec_clk` rise.
- **Espresso purchase:** 7 coins, then `start` with `sel`=0 → `change_valid` pulse with `change`=2 and `credit`=0. Then GRIND for 3 ticks, HEAT 4, POUR 5, DONE 2, then IDLE.
- **Latte and invalid selection:**
  - 5 coins, `start` with `sel`=2 → POUR lasts 9 ticks and `sec_left` counts 9..1.
  - `start` with `sel`=3 → ignored.
- **Cancel paths:**
  - 3 coins then `cancel` → `change`=3.
  - `cancel` during GRIND → `change`=5 (PRICE) and return to IDLE.
  - `cancel` during HEAT → no effect.
- **Boundaries:**
  - 16 coins → `credit` saturates at 15.
  - `coin`+`start` in the same cycle with `credit`=5 → purchase, `change`=0, `credit`=1.
  - `start` with `credit`=4 → ignored.

Source files
------------

// File: rtl/brew_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : brew_controller_if
// Description : Bundles the coffee-machine controller I/O. The slave modport
//               is used by brew_controller; the master modport is used by
//               whatever drives it (panel logic or testbench).
//               i_sec_clk          1 Hz time base from the frequency divider
//               i_coin             one-cycle coin pulse, adds one credit unit
//               i_sel[1:0]         drink code, 0 espresso / 1 americano /
//                                  2 latte / 3 invalid
//               i_start            one-cycle purchase request
//               i_cancel           one-cycle cancel request
//               o_state[2:0]       IDLE=0 GRIND=1 HEAT=2 POUR=3 DONE=4
//               o_credit           current credit
//               o_change           refund amount, valid with o_change_valid
//               o_change_valid     one-cycle refund pulse
//               o_grinder_on       grinder actuator
//               o_heater_on        heater actuator
//               o_pump_on          pump actuator
//               o_busy             high in any state other than IDLE
//               o_done             high in DONE
//               o_sec_left[3:0]    seconds remaining in the current phase
// Revision    : 1.0 - initial release
// ============================================================================
interface brew_controller_if #(
    parameter int CREDIT_W = 4
);
    logic                i_sec_clk;
    logic                i_coin;
    logic [1:0]          i_sel;
    logic                i_start;
    logic                i_cancel;
    logic [2:0]          o_state;
    logic [CREDIT_W-1:0] o_credit;
    logic [CREDIT_W-1:0] o_change;
    logic                o_change_valid;
    logic                o_grinder_on;
    logic                o_heater_on;
    logic                o_pump_on;
    logic                o_busy;
    logic                o_done;
    logic [3:0]          o_sec_left;

    modport slave (
        input  i_sec_clk, i_coin, i_sel, i_start, i_cancel,
        output o_state, o_credit, o_change, o_change_valid,
               o_grinder_on, o_heater_on, o_pump_on, o_busy, o_done, o_sec_left
    );

    modport master (
        output i_sec_clk, i_coin, i_sel, i_start, i_cancel,
        input  o_state, o_credit, o_change, o_change_valid,
               o_grinder_on, o_heater_on, o_pump_on, o_busy, o_done, o_sec_left
    );
endinterface
`default_nettype wire

// File: rtl/brew_controller.sv
`default_nettype none
// ============================================================================
// Module      : brew_controller
// Description : Drink-sequencing controller. Accumulates coin credit, starts a
//               timed GRIND -> HEAT -> POUR -> DONE sequence on a paid
//               purchase, issues change on purchase or cancel, and times each
//               phase from the synchronized rising edges of a 1 Hz clock.
//               clk    system clock
//               rst    asynchronous active-low reset
//               bus    brew_controller_if slave modport (see interface file)
// Revision    : 1.0 - initial release
// ============================================================================
module brew_controller #(
    parameter int PRICE     = 5,
    parameter int CREDIT_W  = 4,
    parameter int GRIND_SEC = 3,
    parameter int HEAT_SEC  = 4,
    parameter int POUR_SEC  = 5,
    parameter int DONE_SEC  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    brew_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRIND = 3'd1,
        S_HEAT  = 3'd2,
        S_POUR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CREDIT_W-1:0] C_PRICE      = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_CREDIT_MAX = '1;
    localparam logic [3:0]          C_GRIND      = 4'(GRIND_SEC);
    localparam logic [3:0]          C_HEAT       = 4'(HEAT_SEC);
    localparam logic [3:0]          C_POUR       = 4'(POUR_SEC);
    localparam logic [3:0]          C_DONE       = 4'(DONE_SEC);

    // ------------------------------------------------------------------
    // Seconds time base
    // ------------------------------------------------------------------
    logic [1:0] r_sec_sync;
    logic       r_sec_prev;
    logic [1:0] r_prime;
    logic       r_armed;
    logic       w_tick;

    // r_prime marks when r_sec_sync[1] holds a real sample; the detector only
    // arms once that sample has been seen low, so a sec_clk that is already
    // high when reset releases cannot produce a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_sync <= 2'b00;
            r_sec_prev <= 1'b0;
            r_prime    <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sec_sync <= {r_sec_sync[0], bus.i_sec_clk};
            r_sec_prev <= r_sec_sync[1];
            r_prime    <= {r_prime[0], 1'b1};
            r_armed    <= r_armed | (r_prime[1] & ~r_sec_sync[1]);
        end
    end

    assign w_tick = r_armed & r_sec_sync[1] & ~r_sec_prev;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state,  w_state_nxt;
    logic [3:0]          r_sec_left, w_sec_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_change, w_change_nxt;
    logic                r_change_valid, w_cv_nxt;
    logic [1:0]          r_sel, w_sel_nxt;
    logic                r_grinder, r_heater, r_pump, r_busy, r_done;

    logic [CREDIT_W-1:0] w_credit_inc;
    logic [CREDIT_W-1:0] w_credit_clr;
    logic [3:0]          w_pour_len;

    // Saturating coin accumulation, active in every state.
    assign w_credit_inc = (bus.i_coin && (r_credit != C_CREDIT_MAX)) ?
                          r_credit + 1'b1 : r_credit;
    // Credit after a refund/purchase: a coin in the same cycle still counts.
    assign w_credit_clr = {{(CREDIT_W-1){1'b0}}, bus.i_coin};
    // Each selection step adds two seconds of pour.
    assign w_pour_len   = C_POUR + {1'b0, r_sel, 1'b0};

    always_comb begin
        w_state_nxt  = r_state;
        w_sec_nxt    = r_sec_left;
        w_credit_nxt = w_credit_inc;
        w_change_nxt = '0;
        w_cv_nxt     = 1'b0;
        w_sel_nxt    = r_sel;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_cancel) begin
                    if (r_credit != '0) begin
                        w_change_nxt = r_credit;
                        w_cv_nxt     = 1'b1;
                        w_credit_nxt = w_credit_clr;
                    end
                end else if (bus.i_start && (r_credit >= C_PRICE) && (bus.i_sel != 2'd3)) begin
                    w_change_nxt = r_credit - C_PRICE;
                    w_cv_nxt     = 1'b1;
                    w_credit_nxt = w_credit_clr;
                    w_sel_nxt    = bus.i_sel;
                    w_sec_nxt    = C_GRIND;
                    w_state_nxt  = S_GRIND;
                end
            end
            S_GRIND: begin
                if (bus.i_cancel) begin
                    w_change_nxt = C_PRICE;
                    w_cv_nxt     = 1'b1;
                    w_sec_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end else if (w_tick) begin
                    if (r_sec_left == 4'd1) begin
                        w_sec_nxt   = C_HEAT;
                        w_state_nxt = S_HEAT;
                    end else begin
                        w_sec_nxt = r_sec_left - 4'd1;
                    end
                end
            end
            S_HEAT: begin
                if (w_tick) begin
                    if (r_sec_left == 4'd1) begin
                        w_sec_nxt   = w_pour_len;
                        w_state_nxt = S_POUR;
                    end else begin
                        w_sec_nxt = r_sec_left - 4'd1;
                    end
                end
            end
            S_POUR: begin
                if (w_tick) begin
                    if (r_sec_left == 4'd1) begin
                        w_sec_nxt   = C_DONE;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_sec_nxt = r_sec_left - 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (w_tick) begin
                    if (r_sec_left == 4'd1) begin
                        w_sec_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_sec_nxt = r_sec_left - 4'd1;
                    end
                end
            end
            default: begin
                w_sec_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Actuator and status flags are decoded from the next state so that they
    // are registered and move on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_sec_left     <= '0;
            r_credit       <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_sel          <= 2'd0;
            r_grinder      <= 1'b0;
            r_heater       <= 1'b0;
            r_pump         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sec_left     <= w_sec_nxt;
            r_credit       <= w_credit_nxt;
            r_change       <= w_change_nxt;
            r_change_valid <= w_cv_nxt;
            r_sel          <= w_sel_nxt;
            r_grinder      <= (w_state_nxt == S_GRIND);
            r_heater       <= (w_state_nxt == S_HEAT);
            r_pump         <= (w_state_nxt == S_POUR);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.o_state        = r_state;
    assign bus.o_sec_left     = r_sec_left;
    assign bus.o_credit       = r_credit;
    assign bus.o_change       = r_change;
    assign bus.o_change_valid = r_change_valid;
    assign bus.o_grinder_on   = r_grinder;
    assign bus.o_heater_on    = r_heater;
    assign bus.o_pump_on      = r_pump;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_brew_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_brew_controller
// Description : Self-checking bench for brew_controller. Stimulus pushes the
//               expected observable events (change pulses and state entries)
//               into a queue; a monitor pops and compares each event the DUT
//               presents. Direct checks cover reset, ignored requests,
//               saturation and the seconds countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brew_controller;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   sec_run = 1'b1;

    brew_controller_if #(.CREDIT_W(CW)) bus ();

    brew_controller #(
        .PRICE(5), .CREDIT_W(CW), .GRIND_SEC(3), .HEAT_SEC(4),
        .POUR_SEC(5), .DONE_SEC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // 1 Hz stand-in: 20 clk periods, can be frozen at its current level.
    initial begin
        bus.i_sec_clk = 1'b0;
        forever begin
            #100;
            if (sec_run) bus.i_sec_clk = ~bus.i_sec_clk;
        end
    end

    typedef struct packed {
        logic       cv;
        logic [3:0] chg;
        logic [2:0] st;
        logic [3:0] sec;
        logic [3:0] cr;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [2:0] prev_state = 3'd0;

    function automatic ev_t mk(input int cv, input int chg, input int st,
                               input int sec, input int cr);
        ev_t e;
        e.cv  = cv[0];
        e.chg = chg[3:0];
        e.st  = st[2:0];
        e.sec = sec[3:0];
        e.cr  = cr[3:0];
        return e;
    endfunction

    // Monitor: an event is a change pulse or a state change.
    always @(negedge clk) begin : mon
        ev_t act, ex;
        if (mon_en && rst && (bus.o_change_valid || (bus.o_state != prev_state))) begin
            act = {bus.o_change_valid, bus.o_change, bus.o_state, bus.o_sec_left, bus.o_credit};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got cv=%0d chg=%0d st=%0d sec=%0d cr=%0d, expected none",
                         act.cv, act.chg, act.st, act.sec, act.cr);
            end else begin
                ex = exp_q.pop_front();
                if (act !== ex)
                begin
                    n_fail++;
                    $display("FAIL event: got cv=%0d chg=%0d st=%0d sec=%0d cr=%0d, expected cv=%0d chg=%0d st=%0d sec=%0d cr=%0d",
                             act.cv, act.chg, act.st, act.sec, act.cr,
                             ex.cv, ex.chg, ex.st, ex.sec, ex.cr);
                end
            end
        end
        prev_state = bus.o_state;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic coins(input int n);
        repeat (n) begin
            @(posedge clk); #1 bus.i_coin = 1'b1;
            @(posedge clk); #1 bus.i_coin = 1'b0;
        end
    endtask

    task automatic do_start(input logic [1:0] s);
        @(posedge clk); #1 bus.i_sel = s; bus.i_start = 1'b1;
        @(posedge clk); #1 bus.i_start = 1'b0;
    endtask

    task automatic do_cancel();
        @(posedge clk); #1 bus.i_cancel = 1'b1;
        @(posedge clk); #1 bus.i_cancel = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.o_state == s[2:0]) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: state=%0d expected %0d", name, bus.o_state, s);
        end
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: pending events %0d expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        bus.i_coin   = 1'b0;
        bus.i_sel    = 2'd0;
        bus.i_start  = 1'b0;
        bus.i_cancel = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",  bus.o_state, 0);
        chk("rst_credit", bus.o_credit, 0);
        chk("rst_cv",     bus.o_change_valid, 0);
        chk("rst_busy",   bus.o_busy, 0);
        chk("rst_secl",   bus.o_sec_left, 0);
        chk("rst_act",    {bus.o_grinder_on, bus.o_heater_on, bus.o_pump_on, bus.o_done}, 0);
        @(posedge clk); #1 rst = 1'b1;
        mon_en = 1'b1;

        // Start with credit 4 is ignored; cancel refunds 4
        coins(4);
        do_start(2'd0);
        idle_cycles(5);
        chk("start_low_state",  bus.o_state, 0);
        chk("start_low_credit", bus.o_credit, 4);
        exp_q.push_back(mk(1, 4, 0, 0, 0));
        do_cancel();
        drain(20, "cancel4");

        // 3 coins then cancel
        coins(3);
        exp_q.push_back(mk(1, 3, 0, 0, 0));
        do_cancel();
        drain(20, "cancel3");

        // Espresso: 7 coins, change 2, full sequence
        coins(7);
        exp_q.push_back(mk(1, 2, 1, 3, 0));
        exp_q.push_back(mk(0, 0, 2, 4, 0));
        exp_q.push_back(mk(0, 0, 3, 5, 0));
        exp_q.push_back(mk(0, 0, 4, 2, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        do_start(2'd0);
        drain(800, "espresso");

        // Latte: pour 9 seconds; sel change after start must not matter
        coins(5);
        exp_q.push_back(mk(1, 0, 1, 3, 0));
        exp_q.push_back(mk(0, 0, 2, 4, 0));
        exp_q.push_back(mk(0, 0, 3, 9, 0));
        exp_q.push_back(mk(0, 0, 4, 2, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        do_start(2'd2);
        bus.i_sel = 2'd0;
        wait_state(3, 400, "latte_pour");
        for (int k = 9; k >= 1; k--) begin
            int b;
            chk($sformatf("latte_secl_%0d", k), bus.o_sec_left, k);
            b = 0;
            while (b < 40 && bus.o_sec_left == k[3:0] && bus.o_state == 3'd3) begin
                @(negedge clk);
                b++;
            end
        end
        drain(200, "latte");

        // Invalid selection ignored
        coins(5);
        do_start(2'd3);
        idle_cycles(5);
        chk("sel3_state",  bus.o_state, 0);
        chk("sel3_credit", bus.o_credit, 5);

        // Coin + start same cycle at credit 5, then cancel in GRIND, then in IDLE
        exp_q.push_back(mk(1, 0, 1, 3, 1));
        @(posedge clk); #1 bus.i_coin = 1'b1; bus.i_start = 1'b1; bus.i_sel = 2'd0;
        @(posedge clk); #1 bus.i_coin = 1'b0; bus.i_start = 1'b0;
        idle_cycles(3);
        exp_q.push_back(mk(1, 5, 0, 0, 1));
        do_cancel();
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        do_cancel();
        drain(20, "coin_start");

        // Cancel during HEAT has no effect
        coins(5);
        exp_q.push_back(mk(1, 0, 1, 3, 0));
        exp_q.push_back(mk(0, 0, 2, 4, 0));
        exp_q.push_back(mk(0, 0, 3, 5, 0));
        exp_q.push_back(mk(0, 0, 4, 2, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        do_start(2'd0);
        wait_state(2, 200, "heat");
        do_cancel();
        idle_cycles(3);
        chk("heat_cancel_state", bus.o_state, 2);
        drain(800, "heat_cancel");

        // Saturation at 15
        coins(16);
        idle_cycles(2);
        chk("sat_credit", bus.o_credit, 15);
        exp_q.push_back(mk(1, 15, 0, 0, 0));
        do_cancel();
        drain(20, "sat");

        // Reset mid-POUR with credit accumulated during busy
        coins(5);
        exp_q.push_back(mk(1, 0, 1, 3, 0));
        exp_q.push_back(mk(0, 0, 2, 4, 3));
        exp_q.push_back(mk(0, 0, 3, 5, 3));
        do_start(2'd0);
        coins(3);
        wait_state(3, 400, "rst_pour");
        drain(20, "rst_pour");
        chk("pre_rst_credit", bus.o_credit, 3);
        @(posedge bus.i_sec_clk);
        sec_run = 1'b0;
        mon_en  = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("rst_pump",   bus.o_pump_on, 0);
        chk("rst_busy2",  bus.o_busy, 0);
        chk("rst_state2", bus.o_state, 0);
        chk("rst_credit2", bus.o_credit, 0);
        #20;
        @(posedge clk); #1 rst = 1'b1;
        mon_en = 1'b1;

        // sec_clk held high across release: no tick until it rises again
        coins(5);
        exp_q.push_back(mk(1, 0, 1, 3, 0));
        do_start(2'd0);
        idle_cycles(60);
        chk("no_tick_secl",  bus.o_sec_left, 3);
        chk("no_tick_state", bus.o_state, 1);
        sec_run = 1'b1;
        for (int i = 0; i < 100 && bus.o_sec_left == 4'd3; i++) @(negedge clk);
        chk("resume_secl", bus.o_sec_left, 2);
        exp_q.push_back(mk(1, 5, 0, 0, 0));
        do_cancel();
        drain(20, "grind_cancel");

        idle_cycles(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
